mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single-port 256x32 word memory file between two requesters: instruction fetch (read-only) and data load/store.
- Sits between the core's fetch/LSU logic and the memory file.
- Owns the memory's address, write_enable and write_data pins.
- Sequences each access through a fixed wait-state window and returns data with a valid pulse.

Parameters:
DATA_W, 32, data width of requesters and memory
ADDR_W, 32, address width (memory decodes [7:0]; arbiter passes full width)
MEM_LATENCY, 1, cycles the memory pins are held per access, legal range 1..15
STARVE_LIMIT, 4, consecutive contested data grants before fetch is forced to win, range 1..15

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
if_req  input  1  fetch request, held high until if_ready
if_addr  input  ADDR_W  fetch address
if_ready  output  1  one-cycle pulse: fetch request accepted
if_rdata  output  DATA_W  fetch read data, registered
if_valid  output  1  one-cycle pulse: if_rdata valid
d_req  input  1  data request, held high until d_ready
d_we  input  1  1 = store, 0 = load
d_addr  input  ADDR_W  data address
d_wdata  input  DATA_W  store data
d_ready  output  1  one-cycle pulse: data request accepted
d_rdata  output  DATA_W  load data, registered
d_valid  output  1  one-cycle pulse: load data valid / store complete
mem_address  output  ADDR_W  to memory file address
mem_write_enable  output  1  to memory file write_enable
mem_write_data  output  DATA_W  to memory file write_data
mem_read_data  input  DATA_W  from memory file read_data

Behaviour:
- Reset (rst_n low at rising edge):
  - State goes to IDLE; wait counter and starve counter go to 0.
  - All outputs go to 0, including rdata registers and mem_* pins.
  - Reset mid-access aborts the access. No valid pulse is issued, and mem_write_enable is 0 from that edge.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If neither request is high, stay in IDLE.
  - Otherwise select a winner:
    - d_req only: data wins.
    - if_req only: fetch wins.
    - Both high: data wins, unless starve counter == STARVE_LIMIT, in which case fetch wins.
  - In the selection cycle, pulse the winner's ready combinationally. This is the only cycle ready is high.
  - The winner's address, we and wdata are latched at that edge.
  - Next state is ACCESS; wait counter loads MEM_LATENCY-1.
  - The loser's request stays pending. Its requester keeps the req high.
- Starve counter:
  - On a data grant while if_req is also high: +1, saturating at STARVE_LIMIT.
  - On any fetch grant: cleared to 0.
  - On an uncontested data grant: unchanged.
- ACCESS:
  - mem_address = latched address.
  - mem_write_data = latched wdata, or 0 for fetch.
  - mem_write_enable = 1 for every ACCESS cycle of a store; 0 otherwise.
  - Wait counter decrements each cycle. When it reaches 0, go to RESP.
  - On that last ACCESS edge, for loads and fetches, mem_read_data is captured into the owner's rdata register.
- RESP:
  - Owner's valid is high for exactly one cycle; mem_write_enable is 0; next state is IDLE.
  - Stores pulse d_valid; d_rdata is unchanged.
- Outside ACCESS:
  - mem_write_enable = 0.
  - mem_address and mem_write_data hold their last values.
- Latency and throughput:
  - From ready to valid is MEM_LATENCY+1 cycles.
  - A back-to-back request is granted in the cycle after RESP.
  - Peak throughput is one access per MEM_LATENCY+2 cycles.
- rdata registers hold until the next completed access to the same port.
- Invariant: only one access is in flight; ready and valid are never asserted for both ports in the same cycle.
- Only addr[7:0] select a word downstream. Addresses that alias mod 256 hit the same word; the arbiter does no checking.

Test Plan:
1. Store then load, MEM_LATENCY=1: d_we=1, d_addr=0x05, d_wdata=0xDEADBEEF.
   - Expect d_ready at cycle 0, mem_write_enable high in cycle 1 only, d_valid at cycle 2.
   - A subsequent load of 0x05 returns d_rdata=0xDEADBEEF with d_valid 2 cycles after d_ready.
2. Fetch-only read of addr 0x10 after memory reset: if_ready, then if_valid 2 cycles later with if_rdata=0; d_ready never asserts.
3. Contention, STARVE_LIMIT=4, if_req and d_req held continuously:
   - Grant order is D, D, D, D, F, D, D, D, D, F.
   - if_valid follows every fifth grant.
4. MEM_LATENCY=3, store to 0x20:
   - mem_write_enable high for exactly 3 consecutive cycles.
   - d_valid asserts 4 cycles after d_ready.
   - Address 0x120 (alias) read returns the same data.
5. Reset mid-access: assert rst_n=0 during the second ACCESS cycle of a MEM_LATENCY=3 store.
   - Next edge: all outputs 0, no d_valid.
   - After release, a new request is granted in the first IDLE cycle.
6. Simultaneous requests arriving while the arbiter is busy (in ACCESS): no ready pulse until IDLE; then data is granted, and fetch follows in the cycle after data's RESP.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter_if
//  Description : Bundles the fetch requester, data requester and memory-file
//                pins that pass through the memory port arbiter.
//                slave  - arbiter side (takes requests, drives memory pins)
//                master - environment side (issues requests, models memory)
//  Signals     : if_req/if_addr/if_ready/if_rdata/if_valid   fetch port
//                d_req/d_we/d_addr/d_wdata/d_ready/d_rdata/d_valid  data port
//                mem_address/mem_write_enable/mem_write_data/mem_read_data
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ready;
  logic [DATA_W-1:0] if_rdata;
  logic              if_valid;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ready;
  logic [DATA_W-1:0] d_rdata;
  logic              d_valid;

  logic [ADDR_W-1:0] mem_address;
  logic              mem_write_enable;
  logic [DATA_W-1:0] mem_write_data;
  logic [DATA_W-1:0] mem_read_data;

  modport slave (
    input  if_req, if_addr,
    output if_ready, if_rdata, if_valid,
    input  d_req, d_we, d_addr, d_wdata,
    output d_ready, d_rdata, d_valid,
    output mem_address, mem_write_enable, mem_write_data,
    input  mem_read_data
  );

  modport master (
    output if_req, if_addr,
    input  if_ready, if_rdata, if_valid,
    output d_req, d_we, d_addr, d_wdata,
    input  d_ready, d_rdata, d_valid,
    input  mem_address, mem_write_enable, mem_write_data,
    output mem_read_data
  );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Shares a single-port 256x32 memory file between instruction
//                fetch (read-only) and data load/store. One access in flight;
//                each access holds the memory pins for MEM_LATENCY cycles,
//                then the owner gets a one-cycle valid pulse.
//  Ports       : clk   - system clock, all state on rising edge
//                rst_n - synchronous active-low reset
//                bus   - mem_port_arbiter_if.slave (requesters + memory pins)
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 32,
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  mem_port_arbiter_if.slave   bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  localparam logic [3:0] c_WAIT_INIT  = 4'(MEM_LATENCY - 1);
  localparam logic [3:0] c_STARVE_MAX = 4'(STARVE_LIMIT);

  logic [1:0]        state_q, state_d;
  logic [3:0]        wait_q, wait_d;
  logic [3:0]        starve_q, starve_d;
  logic              owner_if_q, owner_if_d;   // 1 = fetch owns the access
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

  logic w_fetch_wins;
  logic w_grant_if;
  logic w_grant_d;

  // Data has priority on contention unless fetch has lost STARVE_LIMIT
  // contested rounds in a row. Grants are suppressed while reset is low so
  // no ready pulse escapes during reset.
  assign w_fetch_wins = bus.if_req && (!bus.d_req || (starve_q == c_STARVE_MAX));
  assign w_grant_if   = rst_n && (state_q == S_IDLE) && w_fetch_wins;
  assign w_grant_d    = rst_n && (state_q == S_IDLE) && bus.d_req && !w_fetch_wins;

  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    starve_d   = starve_q;
    owner_if_d = owner_if_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;

    case (state_q)
      S_IDLE: begin
        if (w_grant_if) begin
          state_d    = S_ACCESS;
          wait_d     = c_WAIT_INIT;
          starve_d   = 4'd0;
          owner_if_d = 1'b1;
          we_d       = 1'b0;
          addr_d     = bus.if_addr;
          wdata_d    = '0;
        end else if (w_grant_d) begin
          state_d    = S_ACCESS;
          wait_d     = c_WAIT_INIT;
          owner_if_d = 1'b0;
          we_d       = bus.d_we;
          addr_d     = bus.d_addr;
          wdata_d    = bus.d_wdata;
          // Only a contested data win counts toward fetch starvation.
          if (bus.if_req && (starve_q != c_STARVE_MAX)) begin
            starve_d = starve_q + 4'd1;
          end
        end
      end
      S_ACCESS: begin
        if (wait_q == 4'd0) begin
          state_d = S_RESP;
          if (!we_q) begin
            if (owner_if_q) begin
              if_rdata_d = bus.mem_read_data;
            end else begin
              d_rdata_d = bus.mem_read_data;
            end
          end
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      wait_q     <= 4'd0;
      starve_q   <= 4'd0;
      owner_if_q <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      starve_q   <= starve_d;
      owner_if_q <= owner_if_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  assign bus.if_ready         = w_grant_if;
  assign bus.d_ready          = w_grant_d;
  assign bus.if_valid         = (state_q == S_RESP) && owner_if_q;
  assign bus.d_valid          = (state_q == S_RESP) && !owner_if_q;
  assign bus.if_rdata         = if_rdata_q;
  assign bus.d_rdata          = d_rdata_q;
  // Address and write data are registers, so they hold between accesses;
  // write enable is only live while a store is in ACCESS.
  assign bus.mem_address      = addr_q;
  assign bus.mem_write_data   = wdata_q;
  assign bus.mem_write_enable = (state_q == S_ACCESS) && we_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_port_arbiter
//  Description : Self-checking bench for mem_port_arbiter. Instance A runs
//                with MEM_LATENCY=1, instance B with MEM_LATENCY=3; both use
//                STARVE_LIMIT=4 and a 256-word behavioural memory file.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst_na = 1'b0;
  logic rst_nb = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.DATA_W(32), .ADDR_W(32)) ifa ();
  mem_port_arbiter_if #(.DATA_W(32), .ADDR_W(32)) ifb ();

  mem_port_arbiter #(.DATA_W(32), .ADDR_W(32), .MEM_LATENCY(1), .STARVE_LIMIT(4))
    u_dut_a (.clk(clk), .rst_n(rst_na), .bus(ifa));
  mem_port_arbiter #(.DATA_W(32), .ADDR_W(32), .MEM_LATENCY(3), .STARVE_LIMIT(4))
    u_dut_b (.clk(clk), .rst_n(rst_nb), .bus(ifb));

  // Behavioural memory files: asynchronous read, write on rising edge.
  logic [31:0] mem_a [256];
  logic [31:0] mem_b [256];
  initial begin
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
    end
  end
  always @(posedge clk) begin
    if (ifa.mem_write_enable) mem_a[ifa.mem_address[7:0]] <= ifa.mem_write_data;
    if (ifb.mem_write_enable) mem_b[ifb.mem_address[7:0]] <= ifb.mem_write_data;
  end
  assign ifa.mem_read_data = mem_a[ifa.mem_address[7:0]];
  assign ifb.mem_read_data = mem_b[ifb.mem_address[7:0]];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drv_a(input logic ir, input logic [31:0] ia, input logic dr,
                       input logic dwe, input logic [31:0] da, input logic [31:0] dw);
    ifa.if_req = ir; ifa.if_addr = ia;
    ifa.d_req = dr; ifa.d_we = dwe; ifa.d_addr = da; ifa.d_wdata = dw;
  endtask

  task automatic drv_b(input logic ir, input logic [31:0] ia, input logic dr,
                       input logic dwe, input logic [31:0] da, input logic [31:0] dw);
    ifb.if_req = ir; ifb.if_addr = ia;
    ifb.d_req = dr; ifb.d_we = dwe; ifb.d_addr = da; ifb.d_wdata = dw;
  endtask

  typedef struct packed {
    logic        if_req;
    logic [31:0] if_addr;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        x_if_ready;
    logic        x_d_ready;
    logic        x_if_valid;
    logic        x_d_valid;
    logic        x_we;
    logic [31:0] x_maddr;
    logic [31:0] x_mwdata;
    logic [31:0] x_if_rdata;
    logic [31:0] x_d_rdata;
  } vec_t;

  vec_t tbl [11];

  initial begin
    // Cycle-by-cycle vectors for instance A (MEM_LATENCY=1).
    //           ireq iaddr   dreq we daddr  dwdata        ir dr iv dv we maddr  mwdata        if_rdata d_rdata
    tbl[0]  = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0, 32'h0,       1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0,  32'h0,        32'h0, 32'h0};
    tbl[1]  = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h5, 32'hDEADBEEF,1'b0,1'b1,1'b0,1'b0,1'b0, 32'h0,  32'h0,        32'h0, 32'h0};
    tbl[2]  = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0, 32'h0,       1'b0,1'b0,1'b0,1'b0,1'b1, 32'h5,  32'hDEADBEEF, 32'h0, 32'h0};
    tbl[3]  = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0, 32'h0,       1'b0,1'b0,1'b0,1'b1,1'b0, 32'h5,  32'hDEADBEEF, 32'h0, 32'h0};
    tbl[4]  = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h5, 32'h0,       1'b0,1'b1,1'b0,1'b0,1'b0, 32'h5,  32'hDEADBEEF, 32'h0, 32'h0};
    tbl[5]  = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0, 32'h0,       1'b0,1'b0,1'b0,1'b0,1'b0, 32'h5,  32'h0,        32'h0, 32'h0};
    tbl[6]  = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0, 32'h0,       1'b0,1'b0,1'b0,1'b1,1'b0, 32'h5,  32'h0,        32'h0, 32'hDEADBEEF};
    tbl[7]  = '{1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0,       1'b1,1'b0,1'b0,1'b0,1'b0, 32'h5,  32'h0,        32'h0, 32'hDEADBEEF};
    tbl[8]  = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0, 32'h0,       1'b0,1'b0,1'b0,1'b0,1'b0, 32'h10, 32'h0,        32'h0, 32'hDEADBEEF};
    tbl[9]  = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0, 32'h0,       1'b0,1'b0,1'b1,1'b0,1'b0, 32'h10, 32'h0,        32'h0, 32'hDEADBEEF};
    tbl[10] = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0, 32'h0,       1'b0,1'b0,1'b0,1'b0,1'b0, 32'h10, 32'h0,        32'h0, 32'hDEADBEEF};

    drv_a(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    drv_b(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (3) @(negedge clk);
    rst_na = 1'b1;
    rst_nb = 1'b1;

    // ---- Table: reset state, store/load 0x05, fetch 0x10 ----
    for (int v = 0; v < 11; v++) begin
      drv_a(tbl[v].if_req, tbl[v].if_addr, tbl[v].d_req, tbl[v].d_we, tbl[v].d_addr, tbl[v].d_wdata);
      #1;
      chk($sformatf("v%0d if_ready", v), 32'(ifa.if_ready), 32'(tbl[v].x_if_ready));
      chk($sformatf("v%0d d_ready", v),  32'(ifa.d_ready),  32'(tbl[v].x_d_ready));
      chk($sformatf("v%0d if_valid", v), 32'(ifa.if_valid), 32'(tbl[v].x_if_valid));
      chk($sformatf("v%0d d_valid", v),  32'(ifa.d_valid),  32'(tbl[v].x_d_valid));
      chk($sformatf("v%0d mem_we", v),   32'(ifa.mem_write_enable), 32'(tbl[v].x_we));
      chk($sformatf("v%0d mem_addr", v), ifa.mem_address,    tbl[v].x_maddr);
      chk($sformatf("v%0d mem_wdata", v), ifa.mem_write_data, tbl[v].x_mwdata);
      chk($sformatf("v%0d if_rdata", v), ifa.if_rdata, tbl[v].x_if_rdata);
      chk($sformatf("v%0d d_rdata", v),  ifa.d_rdata,  tbl[v].x_d_rdata);
      @(negedge clk);
    end

    // ---- Contention on A: both held; grant order D,D,D,D,F repeated ----
    drv_a(1'b1, 32'h5, 1'b1, 1'b0, 32'h5, 32'h0);
    for (int k = 0; k < 10; k++) begin
      #1;
      chk($sformatf("cont%0d if_ready", k), 32'(ifa.if_ready), 32'((k % 5) == 4));
      chk($sformatf("cont%0d d_ready", k),  32'(ifa.d_ready),  32'((k % 5) != 4));
      @(negedge clk);
      #1;
      chk($sformatf("cont%0d busy ready", k), 32'({ifa.if_ready, ifa.d_ready}), 32'h0);
      @(negedge clk);
      #1;
      chk($sformatf("cont%0d if_valid", k), 32'(ifa.if_valid), 32'((k % 5) == 4));
      chk($sformatf("cont%0d d_valid", k),  32'(ifa.d_valid),  32'((k % 5) != 4));
      chk($sformatf("cont%0d resp ready", k), 32'({ifa.if_ready, ifa.d_ready}), 32'h0);
      if ((k % 5) == 4) chk($sformatf("cont%0d if_rdata", k), ifa.if_rdata, 32'hDEADBEEF);
      @(negedge clk);
    end
    drv_a(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

    // ---- B: MEM_LATENCY=3 store 0x20, alias read 0x120 ----
    drv_b(1'b0, 32'h0, 1'b1, 1'b1, 32'h20, 32'hCAFEF00D);
    #1 chk("b_st d_ready", 32'(ifb.d_ready), 32'h1);
    chk("b_st we@grant", 32'(ifb.mem_write_enable), 32'h0);
    @(negedge clk);
    drv_b(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("b_st acc%0d we", i), 32'(ifb.mem_write_enable), 32'h1);
      chk($sformatf("b_st acc%0d d_valid", i), 32'(ifb.d_valid), 32'h0);
      chk($sformatf("b_st acc%0d addr", i), ifb.mem_address, 32'h20);
      @(negedge clk);
    end
    #1;
    chk("b_st resp we", 32'(ifb.mem_write_enable), 32'h0);
    chk("b_st resp d_valid", 32'(ifb.d_valid), 32'h1);
    @(negedge clk);
    drv_b(1'b0, 32'h0, 1'b1, 1'b0, 32'h120, 32'h0);
    #1 chk("b_ld d_ready", 32'(ifb.d_ready), 32'h1);
    @(negedge clk);
    drv_b(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      #1 chk($sformatf("b_ld acc%0d d_valid", i), 32'(ifb.d_valid), 32'h0);
      @(negedge clk);
    end
    #1;
    chk("b_ld resp d_valid", 32'(ifb.d_valid), 32'h1);
    chk("b_ld d_rdata", ifb.d_rdata, 32'hCAFEF00D);
    chk("b_ld mem_addr", ifb.mem_address, 32'h120);
    @(negedge clk);

    // ---- B: reset during second ACCESS cycle of a store ----
    drv_b(1'b0, 32'h0, 1'b1, 1'b1, 32'h30, 32'h12345678);
    #1 chk("b_rst d_ready", 32'(ifb.d_ready), 32'h1);
    @(negedge clk);
    drv_b(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1 chk("b_rst acc1 we", 32'(ifb.mem_write_enable), 32'h1);
    @(negedge clk);
    rst_nb = 1'b0;
    #1 chk("b_rst acc2 we", 32'(ifb.mem_write_enable), 32'h1);
    @(negedge clk);
    #1;
    chk("b_rst we", 32'(ifb.mem_write_enable), 32'h0);
    chk("b_rst d_valid", 32'(ifb.d_valid), 32'h0);
    chk("b_rst if_valid", 32'(ifb.if_valid), 32'h0);
    chk("b_rst mem_addr", ifb.mem_address, 32'h0);
    chk("b_rst mem_wdata", ifb.mem_write_data, 32'h0);
    chk("b_rst d_rdata", ifb.d_rdata, 32'h0);
    @(negedge clk);
    #1 chk("b_rst hold d_valid", 32'(ifb.d_valid), 32'h0);
    @(negedge clk);
    rst_nb = 1'b1;
    drv_b(1'b0, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0);
    #1 chk("b_rel d_ready", 32'(ifb.d_ready), 32'h1);
    @(negedge clk);
    drv_b(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      #1 chk($sformatf("b_rel acc%0d d_valid", i), 32'(ifb.d_valid), 32'h0);
      @(negedge clk);
    end
    #1;
    chk("b_rel d_valid", 32'(ifb.d_valid), 32'h1);
    chk("b_rel d_rdata", ifb.d_rdata, 32'hCAFEF00D);
    @(negedge clk);

    // ---- B: both requests arrive while busy ----
    drv_b(1'b0, 32'h0, 1'b1, 1'b1, 32'h40, 32'h0BADF00D);
    #1 chk("b_busy st d_ready", 32'(ifb.d_ready), 32'h1);
    @(negedge clk);
    drv_b(1'b1, 32'h40, 1'b1, 1'b0, 32'h20, 32'h0);
    for (int i = 0; i < 4; i++) begin
      #1 chk($sformatf("b_busy wait%0d ready", i), 32'({ifb.if_ready, ifb.d_ready}), 32'h0);
      if (i == 3) chk("b_busy st d_valid", 32'(ifb.d_valid), 32'h1);
      @(negedge clk);
    end
    #1;
    chk("b_busy grant d_ready", 32'(ifb.d_ready), 32'h1);
    chk("b_busy grant if_ready", 32'(ifb.if_ready), 32'h0);
    @(negedge clk);
    drv_b(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      #1 chk($sformatf("b_busy ld%0d if_ready", i), 32'(ifb.if_ready), 32'h0);
      if (i == 3) begin
        chk("b_busy ld d_valid", 32'(ifb.d_valid), 32'h1);
        chk("b_busy ld d_rdata", ifb.d_rdata, 32'hCAFEF00D);
      end
      @(negedge clk);
    end
    #1;
    chk("b_busy f if_ready", 32'(ifb.if_ready), 32'h1);
    chk("b_busy f d_ready", 32'(ifb.d_ready), 32'h0);
    @(negedge clk);
    drv_b(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (3) @(negedge clk);
    #1;
    chk("b_busy f if_valid", 32'(ifb.if_valid), 32'h1);
    chk("b_busy f if_rdata", ifb.if_rdata, 32'h0BADF00D);
    chk("b_busy f d_valid", 32'(ifb.d_valid), 32'h0);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
